// File: rtl/fpu_pkg.sv
// Shared FPU constants: IEEE-754 single-precision field widths and
// the int32 conversion limits.
package fpu_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;

    localparam logic [EXP_W-1:0] FP_BIAS      = 8'd127;
    // Smallest biased exponent whose magnitude no longer fits in int32.
    localparam logic [EXP_W-1:0] FTOI_SAT_EXP = 8'd158;

    localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN = 32'h8000_0000;

endpackage

// File: rtl/ftoi_shift.sv
// Combinational 32-bit logical right barrel shifter, one mux stage per
// shift-amount bit.
module ftoi_shift (
    input  logic [31:0] din,
    input  logic [4:0]  shamt,
    output logic [31:0] dout
);

    logic [31:0] stage [0:5];

    assign stage[0] = din;

    for (genvar i = 0; i < 5; i++) begin : g_stage
        assign stage[i+1] = shamt[i] ? (stage[i] >> (1 << i)) : stage[i];
    end

    assign dout = stage[5];

endmodule

// File: rtl/ftoi_unit.sv
// Single-precision float to int32 converter, truncating toward zero.
// One registered stage; flag/tag sideband ride alongside the result.
module ftoi_unit
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x,
    input  logic        flagin,
    input  logic [4:0]  addin,
    output logic [31:0] y,
    output logic        flagout,
    output logic [4:0]  addout
);

    // Free-running datapath: no valid/ready, every cycle's operand is
    // accepted and its result appears one clock later.
    logic              sgn;
    logic [EXP_W-1:0]  exp_f;
    logic [FRAC_W-1:0] frac_f;
    logic [4:0]        shamt;
    logic [31:0]       mag;
    logic [31:0]       y_next;

    assign sgn    = x[31];
    assign exp_f  = x[30:23];
    assign frac_f = x[22:0];

    // Only meaningful for FP_BIAS <= exp < FTOI_SAT_EXP, where it is 1..31.
    assign shamt = 5'(FTOI_SAT_EXP - exp_f);

    ftoi_shift u_shift (
        .din   ({1'b1, frac_f, 8'b0}),
        .shamt (shamt),
        .dout  (mag)
    );

    always_comb begin
        y_next = '0;
        if (exp_f < FP_BIAS) begin
            y_next = '0;
        end else if (exp_f >= FTOI_SAT_EXP) begin
            y_next = sgn ? INT32_MIN : INT32_MAX;
        end else begin
            y_next = sgn ? (~mag + 32'd1) : mag;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            y       <= '0;
            flagout <= 1'b0;
            addout  <= '0;
        end else begin
            y       <= y_next;
            flagout <= flagin;
            addout  <= addin;
        end
    end

endmodule

// File: tb/tb_ftoi_unit.sv
// Directed and swept checks for ftoi_unit against a truncating reference.
module tb_ftoi_unit;

    logic        clk;
    logic        rstn;
    logic [31:0] x;
    logic        flagin;
    logic [4:0]  addin;
    logic [31:0] y;
    logic        flagout;
    logic [4:0]  addout;

    int n_checks;
    int n_pass;

    logic [37:0] exp_q[$];

    ftoi_unit dut (
        .clk     (clk),
        .rstn    (rstn),
        .x       (x),
        .flagin  (flagin),
        .addin   (addin),
        .y       (y),
        .flagout (flagout),
        .addout  (addout)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_ftoi(input logic [31:0] v);
        int          e;
        logic [31:0] sig;
        logic [31:0] m;
        e   = int'(v[30:23]);
        sig = {8'b0, 1'b1, v[22:0]};
        if (e < 127) return 32'd0;
        if (e >= 158) return v[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        if (e >= 150) m = sig << (e - 150);
        else          m = sig >> (150 - e);
        return v[31] ? (32'd0 - m) : m;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, expv);
    endtask

    // driver: present one operand, check its result after the next rising edge
    task automatic drive(input string tag, input logic [31:0] xv, input logic fv,
                         input logic [4:0] av, input logic [31:0] yexp);
        logic [37:0] e;
        x      = xv;
        flagin = fv;
        addin  = av;
        exp_q.push_back({fv, av, yexp});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, "_y"}, y, e[31:0]);
        check({tag, "_side"}, {26'd0, flagout, addout}, {26'd0, e[37:32]});
    endtask

    logic [31:0] dir_x [11];
    logic [31:0] dir_y [11];

    initial begin
        dir_x[0]  = 32'h3FC0_0000; dir_y[0]  = 32'h0000_0001;
        dir_x[1]  = 32'hC020_0000; dir_y[1]  = 32'hFFFF_FFFE;
        dir_x[2]  = 32'h4B00_0001; dir_y[2]  = 32'h0080_0001;
        dir_x[3]  = 32'h3F7F_FFFF; dir_y[3]  = 32'h0000_0000;
        dir_x[4]  = 32'h8000_0000; dir_y[4]  = 32'h0000_0000;
        dir_x[5]  = 32'h0000_0001; dir_y[5]  = 32'h0000_0000;
        dir_x[6]  = 32'h4F00_0000; dir_y[6]  = 32'h7FFF_FFFF;
        dir_x[7]  = 32'h4EFF_FFFF; dir_y[7]  = 32'h7FFF_FF80;
        dir_x[8]  = 32'hCF00_0000; dir_y[8]  = 32'h8000_0000;
        dir_x[9]  = 32'h7F80_0000; dir_y[9]  = 32'h7FFF_FFFF;
        dir_x[10] = 32'hFFC0_0000; dir_y[10] = 32'h8000_0000;

        n_checks = 0;
        n_pass   = 0;
        rstn   = 1'b0;
        x      = 32'd0;
        flagin = 1'b0;
        addin  = 5'd0;

        #1;
        check("rst_y", y, 32'd0);
        check("rst_side", {26'd0, flagout, addout}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_y", y, 32'd0);
        #3 rstn = 1'b1;
        @(posedge clk);
        #1;

        // directed vectors with hand-computed results
        for (int i = 0; i < 11; i++)
            drive($sformatf("dir%0d", i), dir_x[i], i[0], 5'(i + 3), dir_y[i]);

        // back-to-back random stream, exponent biased toward interesting range
        for (int i = 0; i < 400; i++) begin
            logic [31:0] v;
            v = $urandom;
            v[30:23] = 8'($urandom_range(120, 165));
            drive("stream", v, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), ref_ftoi(v));
        end

        // strided sweep across the full 32-bit pattern space
        for (int i = 0; i < 20000; i++) begin
            logic [31:0] v;
            v = 32'(i) * 32'h0003_4A1B + 32'h0000_1235;
            drive("sweep", v, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), ref_ftoi(v));
        end

        // reset mid-stream while y is nonzero
        drive("pre_rst", 32'hC2F6_0000, 1'b1, 5'd21, 32'hFFFF_FF85);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_y", y, 32'd0);
        check("mid_rst_side", {26'd0, flagout, addout}, 32'd0);
        @(posedge clk);
        #1;
        check("mid_rst_hold_y", y, 32'd0);
        #3 rstn = 1'b1;
        #1;
        check("post_rel_y", y, 32'd0);
        check("post_rel_side", {26'd0, flagout, addout}, 32'd0);
        @(posedge clk);
        #1;
        drive("post_rst", 32'h4640_E400, 1'b1, 5'd9, 32'h0000_3039);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
